// File: rtl/controller_poller.sv
// rtl/controller_poller.sv - NES controller poller: latch/pulse sequencer with serial button capture
// Optional feature macro: CONTROLLER_POLL_FILTER_EN (commit buttons only when two consecutive frames agree)
module controller_poller #(
    parameter int LATCH_CYCLES = 1200,
    parameter int HALF_CYCLES  = 600,
    parameter int POLL_CYCLES  = 1666667
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       data,
    output logic       latch,
    output logic       pulse,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);
    localparam int PCW    = $clog2(POLL_CYCLES);
    localparam int PH_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
    localparam int PHW    = $clog2(PH_MAX);

    localparam logic [PCW-1:0] POLL_LAST  = PCW'(POLL_CYCLES - 1);
    localparam logic [PHW-1:0] LATCH_LAST = PHW'(LATCH_CYCLES - 1);
    localparam logic [PHW-1:0] HALF_LAST  = PHW'(HALF_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [PCW-1:0] poll_cnt;
    logic [PHW-1:0] phase_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic [1:0]     sync;
    logic           data_s;
    logic           fire;
    logic           phase_last;
    logic [7:0]     frame_byte;
`ifdef CONTROLLER_POLL_FILTER_EN
    logic [7:0]     prev_byte;
`endif

    assign data_s     = sync[1];
    assign fire       = (state == ST_IDLE) && (start || (poll_cnt == POLL_LAST));
    assign phase_last = (state == ST_LATCH) ? (phase_cnt == LATCH_LAST) : (phase_cnt == HALF_LAST);
    // Raw byte as it will stand once the final bit (index 7 -> shift[0]) is captured
    assign frame_byte = {shift[7:1], data_s};

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fire) state_nxt = ST_LATCH;
            ST_LATCH: if (phase_last) state_nxt = ST_LOW;
            ST_LOW:   if (phase_last) state_nxt = (bit_idx == 3'd7) ? ST_DONE : ST_HIGH;
            ST_HIGH:  if (phase_last) state_nxt = ST_LOW;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            poll_cnt  <= '0;
            phase_cnt <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            sync      <= 2'b11;
            latch     <= 1'b0;
            pulse     <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
            buttons   <= 8'h00;
`ifdef CONTROLLER_POLL_FILTER_EN
            prev_byte <= 8'hFF;
`endif
        end else begin
            sync  <= {sync[0], data};
            state <= state_nxt;
            // Outputs registered from the next state so the off-board lines never glitch
            latch <= (state_nxt == ST_LATCH);
            pulse <= (state_nxt == ST_HIGH);
            valid <= (state_nxt == ST_DONE);
            busy  <= (state_nxt != ST_IDLE);

            // Free-running so consecutive latch rises stay exactly one poll period apart
            if (fire || (poll_cnt == POLL_LAST)) begin
                poll_cnt <= '0;
            end else begin
                poll_cnt <= poll_cnt + PCW'(1);
            end

            if (state_nxt != state) begin
                phase_cnt <= '0;
            end else if (state != ST_IDLE) begin
                phase_cnt <= phase_cnt + PHW'(1);
            end

            if (state == ST_LATCH) begin
                bit_idx <= '0;
            end else if ((state == ST_HIGH) && phase_last) begin
                bit_idx <= bit_idx + 3'd1;
            end

            if ((state == ST_LOW) && phase_last) begin
                shift[~bit_idx] <= data_s;
                if (bit_idx == 3'd7) begin
`ifdef CONTROLLER_POLL_FILTER_EN
                    if (frame_byte == prev_byte) begin
                        buttons <= ~frame_byte;
                    end
                    prev_byte <= frame_byte;
`else
                    buttons <= ~frame_byte;
`endif
                end
            end
        end
    end
endmodule

// File: tb/tb_controller_poller.sv
// tb/tb_controller_poller.sv - self-checking bench for controller_poller with a serial pad model
`timescale 1ns/1ps
module tb_controller_poller;
    localparam int LC        = 12;
    localparam int HC        = 6;
    localparam int PC        = 200;
    localparam int FRAME_LEN = LC + 8 * HC + 7 * HC;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       data;
    logic       latch;
    logic       pulse;
    logic [7:0] buttons;
    logic       valid;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    controller_poller #(
        .LATCH_CYCLES(LC),
        .HALF_CYCLES (HC),
        .POLL_CYCLES (PC)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .data   (data),
        .latch  (latch),
        .pulse  (pulse),
        .buttons(buttons),
        .valid  (valid),
        .busy   (busy)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // NES pad: 4021 shift register, latch loads A onto data, each pulse rise shifts the next button
    logic [7:0] pad = 8'h00;
    logic [2:0] pos = 3'd0;
    logic       pad_pulse_d = 1'b0;
    always @(posedge clk) begin
        if (latch) pos <= 3'd0;
        else if (pulse && !pad_pulse_d) pos <= pos + 3'd1;
        pad_pulse_d <= pulse;
    end
    assign data = ~pad[3'd7 - pos];

    // Observation of the frame shape; the initial block reads these #1 after each falling edge
    int rise_cnt = 0, last_rise = 0, valid_cnt = 0, last_valid = 0;
    int lw = 0, lw_last = 0, pc = 0, pc_last = 0, pw = 0;
    int pw_err = 0, busy_err = 0, hold_err = 0;
    logic latch_q = 1'b0, pulse_q = 1'b0, in_frame = 1'b0;
    logic [7:0] held = 8'h00;

    always @(negedge clk) begin
        latch_q <= latch;
        pulse_q <= pulse;
        if (rst) begin
            in_frame <= 1'b0;
            held     <= 8'h00;
            lw       <= 0;
            pw       <= 0;
        end else begin
            if (latch && !latch_q) begin
                rise_cnt  <= rise_cnt + 1;
                last_rise <= cyc;
                pc        <= 0;
            end else if (pulse && !pulse_q) begin
                pc <= pc + 1;
            end
            if (latch) lw <= latch_q ? lw + 1 : 1;
            else if (latch_q) lw_last <= lw;
            if (pulse) pw <= pulse_q ? pw + 1 : 1;
            else if (pulse_q && pw != HC) pw_err <= pw_err + 1;
            if (busy !== (in_frame || (latch && !latch_q))) busy_err <= busy_err + 1;
            if (latch && !latch_q) in_frame <= 1'b1;
            if (valid) begin
                valid_cnt  <= valid_cnt + 1;
                last_valid <= cyc;
                pc_last    <= pc;
                held       <= buttons;
                in_frame   <= 1'b0;
            end else if (buttons !== held) begin
                hold_err <= hold_err + 1;
            end
        end
    end

    // Reference: buttons equal the pad's pressed set; with the filter only when two raw frames agree
    logic [7:0] exp_btn  = 8'h00;
    logic [7:0] prev_raw = 8'hFF;

    task automatic model_reset();
        exp_btn  = 8'h00;
        prev_raw = 8'hFF;
    endtask

    task automatic model_frame(input logic [7:0] p);
        logic [7:0] raw;
        raw = ~p;
`ifdef CONTROLLER_POLL_FILTER_EN
        if (raw == prev_raw) exp_btn = p;
        prev_raw = raw;
`else
        exp_btn = p;
`endif
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) tick();
    endtask

    task automatic wait_rise(input int n0, input int budget);
        int k = 0;
        while (rise_cnt <= n0 && k < budget) begin
            tick();
            k++;
        end
        chk("latch_rise_timeout", 32'(rise_cnt > n0), 1);
    endtask

    task automatic finish_frame(input string tag);
        int n0 = valid_cnt;
        int k = 0;
        while (valid_cnt <= n0 && k < 3 * PC) begin
            tick();
            k++;
        end
        chk({tag, "_valid_timeout"}, 32'(valid_cnt > n0), 1);
        model_frame(pad);
        chk({tag, "_buttons"}, 32'(buttons), 32'(exp_btn));
        chk({tag, "_latch_width"}, lw_last, LC);
        chk({tag, "_pulse_count"}, pc_last, 7);
        chk({tag, "_frame_len"}, last_valid - last_rise, FRAME_LEN);
        tick();
        chk({tag, "_valid_one_cycle"}, 32'(valid), 0);
        chk({tag, "_buttons_hold"}, 32'(buttons), 32'(exp_btn));
    endtask

    task automatic run_frame(input logic [7:0] p, input string tag);
        pad = p;
        finish_frame(tag);
    endtask

    logic [7:0] pat [5] = '{8'h00, 8'hFF, 8'h01, 8'h02, 8'h02};

    initial begin
        int rel, r0, s, n0, vc;
        logic [7:0] p;

        // Reset state
        rst = 1'b1;
        pad = 8'h80;
        repeat (4) tick();
        chk("rst_latch", 32'(latch), 0);
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_buttons", 32'(buttons), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_busy", 32'(busy), 0);

        // Free-running cadence: latch rises at 200, 400, 600 after release
        rst = 1'b0;
        rel = cyc;
        run_frame(8'h80, "a_pressed");
        chk("rise_1", last_rise - rel, PC);
        for (int i = 1; i < 3; i++) begin
            p = 8'($urandom);
            run_frame(p, "free_run");
            chk("rise_n", last_rise - rel, PC * (i + 1));
        end

        // Start while busy is dropped; start in idle latches on the next cycle and restarts the period
        n0 = rise_cnt;
        wait_rise(n0, 2 * PC);
        r0 = last_rise;
        repeat (30) tick();
        chk("busy_mid_frame", 32'(busy), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        finish_frame("mid_start");
        wait_cyc(r0 + 150);
        chk("mid_start_ignored", rise_cnt, n0 + 1);
        chk("idle_not_busy", 32'(busy), 0);
        s = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_latch", 32'(latch), 1);
        chk("start_rise_time", last_rise, s + 1);
        finish_frame("idle_start");
        n0 = rise_cnt;
        wait_rise(n0, 2 * PC);
        chk("counter_restart", last_rise, s + 1 + PC);

        // Start coinciding with the counter's terminal count begins exactly one frame
        r0 = last_rise;
        finish_frame("pre_coincide");
        n0 = rise_cnt;
        wait_cyc(r0 + PC - 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("coincide_rise", last_rise, r0 + PC);
        chk("coincide_one_frame", rise_cnt, n0 + 1);
        finish_frame("coincide");
        wait_rise(n0 + 1, 2 * PC);
        chk("coincide_next", last_rise, r0 + 2 * PC);
        chk("coincide_count", rise_cnt, n0 + 2);
        finish_frame("post_coincide");

        // Directed patterns: unplugged, all pressed, then R, L, L
        for (int i = 0; i < 5; i++) run_frame(pat[i], "pattern");
        for (int i = 0; i < 4; i++) begin
            p = 8'($urandom);
            run_frame(p, "random");
        end

        // Reset during the 4th HIGH phase aborts the frame
        pad = 8'($urandom) | 8'h01;
        n0 = rise_cnt;
        wait_rise(n0, 2 * PC);
        for (int k = 0; k < FRAME_LEN && !(pc == 4 && pulse); k++) tick();
        chk("reached_high4", 32'(pulse), 1);
        tick();
        vc = valid_cnt;
        rst = 1'b1;
        tick();
        chk("abort_latch", 32'(latch), 0);
        chk("abort_pulse", 32'(pulse), 0);
        chk("abort_buttons", 32'(buttons), 0);
        chk("abort_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;
        rel = cyc;
        model_reset();
        n0 = rise_cnt;
        wait_rise(n0, 2 * PC);
        chk("abort_no_valid", valid_cnt, vc);
        chk("abort_next_rise", last_rise - rel, PC);
        finish_frame("after_abort");

        chk("pulse_widths", pw_err, 0);
        chk("busy_window", busy_err, 0);
        chk("buttons_held", hold_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
